// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scanner.
//   SEG_W      width of one digit's segment bus {dp,g,f,e,d,c,b,a}
//   SEG_OFF    segment bus value with every segment dark (active-low)
//   SEG_A..DP  bit positions inside a segment word
//   seg_t      one digit's segment word
package seg7_pkg;
    localparam int SEG_W  = 8;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;
endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: slot timing for the scanner.
//   clock         system clock
//   reset         synchronous, active-high
//   slot_cnt_o    position inside the current digit slot, 0..PRESCALE-1
//   digit_idx_o   digit owning the current slot, 0..NUM_DIGITS-1
//   frame_tick_o  high for the one cycle in which the scan has wrapped back to digit 0
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(PRESCALE)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [CW-1:0] slot_cnt_o,
    output logic [DW-1:0] digit_idx_o,
    output logic          frame_tick_o
);
    localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
    localparam logic [DW-1:0] IDX_LAST  = DW'(NUM_DIGITS - 1);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [DW-1:0] idx_q, idx_d;
    logic          tick_q, tick_d;
    logic          slot_wrap;

    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CW'(1);
        idx_d      = idx_q;
        tick_d     = 1'b0;
        if (slot_wrap) begin
            // With a single digit IDX_LAST is 0, so every wrap is a frame wrap.
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                tick_d = 1'b1;
            end else begin
                idx_d = idx_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
        end
    end

    assign slot_cnt_o   = slot_cnt_q;
    assign digit_idx_o  = idx_q;
    assign frame_tick_o = tick_q;
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed common-anode 7-segment scanner.
//   clock       system clock
//   reset       synchronous, active-high
//   seg_in      per-digit segment words, digit k at [8k+7:8k], active-low
//   digit_en    1 = digit shown, 0 = digit blanked
//   brightness  PWM duty level, 0 dimmest .. all-ones full on
//   blank_all   1 = force all anodes off
//   seg         registered shared segment bus, active-low
//   an          registered anode enables, active-low, at most one low
//   digit_idx   digit currently owning the slot
//   frame_tick  one-cycle pulse when the scan wraps back to digit 0
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 8,
    parameter int BRIGHT_W    = 4,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(PRESCALE)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [BRIGHT_W-1:0]         brightness,
    input  logic                        blank_all,
    output logic [SEG_W-1:0]            seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [DW-1:0]               digit_idx,
    output logic                        frame_tick
);
    if (NUM_DIGITS < 1) begin : g_bad_num_digits
        $error("seg7_scan_mux: NUM_DIGITS must be >= 1");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("seg7_scan_mux: PRESCALE must be >= 2");
    end
    if (DEAD_CYCLES >= PRESCALE) begin : g_bad_dead
        $error("seg7_scan_mux: DEAD_CYCLES must be < PRESCALE");
    end

    logic [CW-1:0] slot_cnt;
    logic [DW-1:0] idx;

    seg7_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .slot_cnt_o   (slot_cnt),
        .digit_idx_o  (idx),
        .frame_tick_o (frame_tick)
    );

    seg_t                  snap_seg_q;
    logic                  snap_en_q;
    logic [BRIGHT_W-1:0]   snap_bright_q;
    logic [BRIGHT_W-1:0]   pwm_q;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    seg_t                  live_seg, eff_seg;
    logic                  live_en, eff_en;
    logic [BRIGHT_W-1:0]   eff_bright;
    logic                  slot_start;
    logic                  lit;

    always_comb begin
        live_seg = SEG_OFF;
        live_en  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == DW'(k)) begin
                live_seg = seg_in[k*SEG_W +: SEG_W];
                live_en  = digit_en[k];
            end
        end

        // The snapshot register only holds the new slot's values from the
        // second cycle on; in the first cycle the live inputs are what the
        // snapshot is capturing, so use them directly. This keeps a zero
        // dead time correct.
        slot_start = (slot_cnt == '0);
        eff_seg    = slot_start ? live_seg   : snap_seg_q;
        eff_en     = slot_start ? live_en    : snap_en_q;
        eff_bright = slot_start ? brightness : snap_bright_q;

        lit = (slot_cnt >= CW'(DEAD_CYCLES)) && eff_en && !blank_all &&
              (pwm_q <= eff_bright);

        an_d  = '1;
        seg_d = SEG_OFF;
        if (lit) begin
            seg_d = eff_seg;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx == DW'(k)) an_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snap_seg_q    <= SEG_OFF;
            snap_en_q     <= 1'b0;
            snap_bright_q <= '0;
            pwm_q         <= '0;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
        end else begin
            if (slot_start) begin
                snap_seg_q    <= live_seg;
                snap_en_q     <= live_en;
                snap_bright_q <= brightness;
            end
            pwm_q <= pwm_q + BRIGHT_W'(1);
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign digit_idx = idx;
endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int D  = 1;
    localparam int BW = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [8*N-1:0] seg_in;
    logic [N-1:0]  digit_en;
    logic [BW-1:0] brightness;
    logic          blank_all;
    logic [7:0]    seg;
    logic [N-1:0]  an;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    seg7_scan_mux #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .DEAD_CYCLES (D),
        .BRIGHT_W    (BW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .seg_in     (seg_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .blank_all  (blank_all),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // At most one anode may be low in any cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL one_hot_an: got an=%b expected at most one low", an);
            end
        end
    end

    // ---------------- reference model ----------------
    // k counts cycles since reset release; slot position, digit and PWM phase
    // all follow from it by plain arithmetic.
    int         k;
    logic [7:0] m_seg;
    logic       m_en;
    logic [1:0] m_br;

    task automatic model_eval(output logic [14:0] e);
        int         slot, dig, pwm;
        logic [31:0] sh;
        logic       lit;
        logic [3:0] a;
        if (reset) begin
            e = {4'hF, 8'hFF, 2'd0, 1'b0};
            k = 0; m_seg = 8'hFF; m_en = 1'b0; m_br = '0;
            return;
        end
        slot = k % P;
        dig  = (k / P) % N;
        pwm  = k % (1 << BW);
        if (slot == 0) begin
            sh    = seg_in >> (8 * dig);
            m_seg = sh[7:0];
            m_en  = digit_en[dig];
            m_br  = brightness;
        end
        lit = (slot >= D) && m_en && !blank_all && (pwm <= int'(m_br));
        a = 4'hF;
        if (lit) a[dig] = 1'b0;
        e = {a, (lit ? m_seg : 8'hFF), 2'(((k + 1) / P) % N), ((k + 1) % (P * N)) == 0};
        k++;
    endtask

    // ---------------- driver / scoreboard ----------------
    logic [14:0] exp_q[$];

    task automatic step();
        logic [14:0] e;
        model_eval(e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        chk("model", {17'd0, an, seg, digit_idx, frame_tick}, {17'd0, exp_q.pop_front()});
    endtask

    task automatic align(input int modulus, input int phase);
        for (int i = 0; i < 64 && (k % modulus) != phase; i++) step();
    endtask

    typedef struct {
        logic       blank;
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] idx;
        logic       tick;
    } vec_t;
    vec_t tbl[16];

    int lit_cnt, tick_cnt, bad_cnt, seen1, tick_bad;

    initial begin
        tbl[0]  = '{1'b0, 4'hF, 8'hFF, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'hE, 8'hC0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'hE, 8'hC0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 4'hE, 8'hC0, 2'd1, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 8'hFF, 2'd1, 1'b0};
        tbl[5]  = '{1'b0, 4'hD, 8'hF9, 2'd1, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 8'hFF, 2'd1, 1'b0};
        tbl[7]  = '{1'b0, 4'hD, 8'hF9, 2'd2, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 8'hFF, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, 4'hB, 8'hB0, 2'd2, 1'b0};
        tbl[10] = '{1'b0, 4'hB, 8'hB0, 2'd2, 1'b0};
        tbl[11] = '{1'b0, 4'hB, 8'hB0, 2'd3, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 8'hFF, 2'd3, 1'b0};
        tbl[13] = '{1'b0, 4'h7, 8'hA4, 2'd3, 1'b0};
        tbl[14] = '{1'b0, 4'h7, 8'hA4, 2'd3, 1'b0};
        tbl[15] = '{1'b0, 4'h7, 8'hA4, 2'd0, 1'b1};

        reset = 1'b1;
        seg_in = {8'hA4, 8'hB0, 8'hF9, 8'hC0};
        digit_en = 4'hF;
        brightness = 2'd3;
        blank_all = 1'b0;
        k = 0; m_seg = 8'hFF; m_en = 1'b0; m_br = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1'b1;
            chk("reset_an", {28'd0, an}, 32'hF);
            chk("reset_seg", {24'd0, seg}, 32'hFF);
        end
        reset = 1'b0;

        // One frame of known digits, with blank_all pulsed for a single cycle.
        for (int i = 0; i < 16; i++) begin
            blank_all = tbl[i].blank;
            step();
            chk($sformatf("tbl%0d", i), {17'd0, an, seg, digit_idx, frame_tick},
                {17'd0, tbl[i].an, tbl[i].seg, tbl[i].idx, tbl[i].tick});
        end
        blank_all = 1'b0;

        // Free run: four single-cycle frame ticks, each at the wrap to digit 0.
        tick_cnt = 0; tick_bad = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_tick) begin
                tick_cnt++;
                if (digit_idx != 2'd0) tick_bad++;
            end
        end
        chk("frame_tick_count", tick_cnt, 4);
        chk("frame_tick_at_wrap", tick_bad, 0);

        // Digit 2 disabled.
        digit_en = 4'b1011;
        bad_cnt = 0; seen1 = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (an == 4'b1011) bad_cnt++;
            if (an == 4'b1101) seen1++;
        end
        chk("digit2_dark", bad_cnt, 0);
        chk("digit1_still_lit", seen1, 16 * (P - D) / 4);
        digit_en = 4'hF;

        // Brightness 0: at most one lit cycle per slot.
        align(P, 0);
        brightness = 2'd0;
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (an != 4'hF) lit_cnt++;
        end
        chk("bright0_max", {31'd0, lit_cnt <= 16}, 1);

        // Brightness 1: lit when pwm_cnt<=1 and past the dead cycle.
        align(P, 0);
        brightness = 2'd1;
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (an != 4'hF) lit_cnt++;
        end
        chk("bright1_count", lit_cnt, 16);

        // Mid-slot change of digit 0's segments is held until its next slot.
        brightness = 2'd3;
        align(P * N, 0);
        seg_in[7:0] = 8'h11;
        step();
        step();
        chk("hold_first", {24'd0, seg}, 32'h11);
        seg_in[7:0] = 8'h22;
        step();
        chk("hold_mid1", {24'd0, seg}, 32'h11);
        step();
        chk("hold_mid2", {24'd0, seg}, 32'h11);
        align(P * N, 0);
        step();
        step();
        chk("hold_new", {24'd0, seg}, 32'h22);

        // Reset in the middle of digit 2's slot; scan restarts at digit 0.
        align(P * N, 2 * P + 2);
        reset = 1'b1;
        step();
        chk("midreset_an", {28'd0, an}, 32'hF);
        chk("midreset_idx", {30'd0, digit_idx}, 32'd0);
        reset = 1'b0;
        step();
        chk("after_reset_dead", {28'd0, an}, 32'hF);
        step();
        chk("after_reset_digit0", {28'd0, an}, 32'hE);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) seg_in = $urandom;
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) brightness = 2'($urandom_range(0, 3));
            blank_all = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
